// File: rtl/jtdsp16_do_cache_pkg.sv
// Shared constants for the DSP16 DO-loop cache: DO operand field widths,
// cache geometry and FSM state encodings.
package jtdsp16_do_cache_pkg;

  localparam int DO_NI_W  = 4;
  localparam int DO_K_W   = 7;
  localparam int DO_DW    = DO_NI_W + DO_K_W;
  localparam int DO_DEPTH = 15;
  localparam int INST_W   = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_REPLAY = 2'd2;

  typedef struct packed {
    logic [DO_NI_W-1:0] ni;
    logic [DO_K_W-1:0]  k;
  } do_req_t;

  function automatic do_req_t unpack_do(input logic [DO_DW-1:0] d);
    do_req_t r;
    r.ni = d[DO_DW-1:DO_K_W];
    r.k  = d[DO_K_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/jtdsp16_do_cache_if.sv
// Decoder-side bundle of the DO-loop cache: DO request, instruction stream in,
// replayed stream out, and loop status flags.
interface jtdsp16_do_cache_if
  import jtdsp16_do_cache_pkg::*;
#(
  parameter int DW = 16
) ();

  // Consumption handshake: the decoder takes one instruction word on every clock
  // with cen && inst_adv; the word it takes is cache_dout when cache_en=1, else
  // rom_dout. cache_dout is stable whenever inst_adv or cen is low, so the word
  // presented is always the word that will be consumed.
  logic              do_start;
  logic [DO_DW-1:0]  do_data;
  logic              inst_adv;
  logic [DW-1:0]     rom_dout;
  logic [DW-1:0]     cache_dout;
  logic              cache_en;
  logic              pc_freeze;
  logic              busy;
  logic              fault;
  logic [1:0]        dbg_state;

  modport master (
    output do_start, do_data, inst_adv, rom_dout,
    input  cache_dout, cache_en, pc_freeze, busy, fault, dbg_state
  );

  modport slave (
    input  do_start, do_data, inst_adv, rom_dout,
    output cache_dout, cache_en, pc_freeze, busy, fault, dbg_state
  );

endinterface

// File: rtl/jtdsp16_do_mem.sv
// Loop-body register file: one synchronous write port, one asynchronous read port.
// Contents are not reset; the controller only reads entries it has filled.
module jtdsp16_do_mem #(
  parameter int DEPTH = 15,
  parameter int DW    = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/jtdsp16_do_cache.sv
// DO-loop instruction cache: captures the NI-word loop body on the first pass
// from ROM and replays it from local storage for the remaining K-1 passes.
module jtdsp16_do_cache
  import jtdsp16_do_cache_pkg::*;
#(
  parameter int DEPTH = DO_DEPTH,
  parameter int DW    = INST_W,
  parameter int KW    = DO_K_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cen,
  jtdsp16_do_cache_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [DO_NI_W:0] DEPTH_L = (DO_NI_W+1)'(DEPTH);

  logic [1:0]         state;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [DO_NI_W-1:0] ni;
  logic [KW-1:0]      cnt;
  logic               cache_valid;
  logic               fault_r;

  do_req_t       req;
  logic [AW-1:0] last_idx;
  logic          req_bad_ni;
  logic          mem_we;
  logic          last_pass;
  logic [KW-1:0] cnt_dec;

  assign req        = unpack_do(bus.do_data);
  assign req_bad_ni = {1'b0, req.ni} > DEPTH_L;
  assign last_idx   = AW'(ni - DO_NI_W'(1));
  // A count of 0 or 1 both mean "this is the final pass"; the counter never wraps.
  assign last_pass  = cnt <= KW'(1);
  assign cnt_dec    = last_pass ? '0 : cnt - KW'(1);
  assign mem_we     = cen && bus.inst_adv && (state == ST_FILL);

  jtdsp16_do_mem #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (bus.rom_dout),
    .raddr (rd_ptr),
    .rdata (bus.cache_dout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ni          <= '0;
      cnt         <= '0;
      cache_valid <= 1'b0;
      fault_r     <= 1'b0;
    end else if (cen) begin
      fault_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.do_start) begin
            if (req.ni != '0 && !req_bad_ni) begin
              ni          <= req.ni;
              cnt         <= KW'(req.k);
              wr_ptr      <= '0;
              cache_valid <= 1'b0;
              state       <= ST_FILL;
            end else if (req.ni == '0 && cache_valid) begin
              cnt    <= KW'(req.k);
              rd_ptr <= '0;
              state  <= ST_REPLAY;
            end else begin
              fault_r <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (bus.do_start) fault_r <= 1'b1;
          if (bus.inst_adv) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (wr_ptr == last_idx) begin
              cache_valid <= 1'b1;
              cnt         <= cnt_dec;
              rd_ptr      <= '0;
              state       <= last_pass ? ST_IDLE : ST_REPLAY;
            end
          end
        end
        ST_REPLAY: begin
          if (bus.do_start) fault_r <= 1'b1;
          if (bus.inst_adv) begin
            if (rd_ptr == last_idx) begin
              rd_ptr <= '0;
              cnt    <= cnt_dec;
              if (last_pass) state <= ST_IDLE;
            end else begin
              rd_ptr <= rd_ptr + AW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Flags decode straight from the state register so they fall in the same
  // cen that returns to IDLE and clear immediately on the async reset.
  assign bus.cache_en  = (state == ST_REPLAY);
  assign bus.pc_freeze = (state == ST_REPLAY);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.fault     = fault_r;
  assign bus.dbg_state = state;

endmodule
